csr_file: RTL and testbench

Machine-mode CSR register file and trap sequencer for the RV32 pipeline, sitting downstream of instruction decode at the commit point. Executes committed CSR read/modify/write operations and ECALL/EBREAK/illegal-instruction trap entry and MRET return. Produces `mstatus`, which decode uses for privilege return, and the redirect PC and pulses used to steer fetch.

---
 rtl/csr_file_if.sv | 45 ++++
 rtl/csr_file.sv | 258 +++++++++++++++++++++++++
 tb/tb_csr_file.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_file_if.sv
// csr_file_if
//
// CSR access channel between the commit stage and csr_file. The commit
// logic (master) presents one committed CSR instruction per cycle; the CSR
// file (slave) answers combinationally with the old register value and an
// illegal-access flag.
//
// Signals:
//   csr_valid    committed CSR instruction this cycle
//   csr_op       funct3 of the instruction (RW/RS/RC and immediate forms)
//   csr_addr     12-bit CSR address
//   csr_rs1_idx  rs1 field, doubles as zimm for immediate forms
//   csr_rs1_val  rs1 register value
//   csr_rdata    old CSR value destined for rd
//   illegal_csr  unimplemented address or write to a read-only address

interface csr_file_if;
    logic        csr_valid;
    logic [2:0]  csr_op;
    logic [11:0] csr_addr;
    logic [4:0]  csr_rs1_idx;
    logic [31:0] csr_rs1_val;
    logic [31:0] csr_rdata;
    logic        illegal_csr;

    modport master (
        output csr_valid,
        output csr_op,
        output csr_addr,
        output csr_rs1_idx,
        output csr_rs1_val,
        input  csr_rdata,
        input  illegal_csr
    );

    modport slave (
        input  csr_valid,
        input  csr_op,
        input  csr_addr,
        input  csr_rs1_idx,
        input  csr_rs1_val,
        output csr_rdata,
        output illegal_csr
    );
endinterface

// File: rtl/csr_file.sv
// csr_file
//
// Machine-mode CSR register file and trap sequencer at the commit point of
// the RV32 pipeline. Executes committed CSR read/modify/write operations,
// performs trap entry for exceptions and the two-phase MRET return, and
// keeps the mcycle/minstret counters.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   csr_bus (slave)          CSR access channel, see csr_file_if
//   exception_i              committed exception this cycle
//   exception_cause_i        value for mcause
//   exception_pc_i           PC of the faulting instruction
//   exception_tval_i         value for mtval
//   mret_i                   committed MRET this cycle
//   instret_i                one instruction retired this cycle
//   current_privilege_i      current privilege level (11 M, 00 U)
//   mstatus_o                current mstatus
//   trap_redirect_o          one-cycle pulse: fetch goes to redirect_pc_o
//   mret_out_o               one-cycle pulse: MRET is completing
//   redirect_pc_o            registered redirect target

module csr_file #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    csr_file_if.slave             csr_bus,
    input  logic                  exception_i,
    input  logic [DATA_WIDTH-1:0] exception_cause_i,
    input  logic [DATA_WIDTH-1:0] exception_pc_i,
    input  logic [DATA_WIDTH-1:0] exception_tval_i,
    input  logic                  mret_i,
    input  logic                  instret_i,
    input  logic [1:0]            current_privilege_i,
    output logic [DATA_WIDTH-1:0] mstatus_o,
    output logic                  trap_redirect_o,
    output logic                  mret_out_o,
    output logic [DATA_WIDTH-1:0] redirect_pc_o
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    localparam logic [DATA_WIDTH-1:0] MISA_VALUE = 32'h4000_1100;
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~32'h0000_0003;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_TRAP,
        SEQ_MRET
    } seqState_t;

    seqState_t seqState_q;

    logic                  trap_redirect_q;
    logic                  mret_out_q;
    logic [DATA_WIDTH-1:0] redirect_pc_q;

    logic                  mie_q,  mie_d;
    logic                  mpie_q, mpie_d;
    logic [1:0]            mpp_q,  mpp_d;
    logic [DATA_WIDTH-1:0] mtvec_q,    mtvec_d;
    logic [DATA_WIDTH-1:0] mscratch_q, mscratch_d;
    logic [DATA_WIDTH-1:0] mepc_q,     mepc_d;
    logic [DATA_WIDTH-1:0] mcause_q,   mcause_d;
    logic [DATA_WIDTH-1:0] mtval_q,    mtval_d;
    logic [63:0]           mcycle_q,   mcycle_d;
    logic [63:0]           minstret_q, minstret_d;

    logic [DATA_WIDTH-1:0] mstatusView;
    logic [DATA_WIDTH-1:0] readData;
    logic                  addrImplemented;
    logic                  addrReadOnly;
    logic                  wantWrite;
    logic                  illegal;
    logic                  csrWrite;
    logic [DATA_WIDTH-1:0] writeSrc;
    logic [DATA_WIDTH-1:0] writeData;
    logic [63:0]           mcycleInc;
    logic [63:0]           minstretInc;

    // Only MIE, MPIE and MPP are stored; every other mstatus bit reads zero.
    assign mstatusView = {19'd0, mpp_q, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};

    // Address decode and read mux. Reads are zero latency and return the
    // value held before this cycle's edge, which is what rd receives.
    always_comb begin
        readData        = '0;
        addrImplemented = 1'b1;
        addrReadOnly    = 1'b0;
        case (csr_bus.csr_addr)
            ADDR_MSTATUS:   readData = mstatusView;
            ADDR_MISA: begin
                readData     = MISA_VALUE;
                addrReadOnly = 1'b1;
            end
            ADDR_MTVEC:     readData = mtvec_q;
            ADDR_MSCRATCH:  readData = mscratch_q;
            ADDR_MEPC:      readData = mepc_q;
            ADDR_MCAUSE:    readData = mcause_q;
            ADDR_MTVAL:     readData = mtval_q;
            ADDR_MCYCLE:    readData = mcycle_q[31:0];
            ADDR_MCYCLEH:   readData = mcycle_q[63:32];
            ADDR_MINSTRET:  readData = minstret_q[31:0];
            ADDR_MINSTRETH: readData = minstret_q[63:32];
            ADDR_MHARTID: begin
                readData     = '0;
                addrReadOnly = 1'b1;
            end
            default:        addrImplemented = 1'b0;
        endcase
    end

    // Write qualification and new-value computation. Set/clear forms with
    // rs1/zimm of zero are pure reads, so they never write and may target
    // read-only registers. Exception and MRET outrank a CSR write.
    always_comb begin
        wantWrite = csr_bus.csr_valid && (csr_bus.csr_op[1:0] != 2'b00)
                    && !(csr_bus.csr_op[1] && (csr_bus.csr_rs1_idx == 5'd0));
        illegal   = csr_bus.csr_valid
                    && (!addrImplemented || (addrReadOnly && wantWrite));
        writeSrc  = csr_bus.csr_op[2] ? {27'd0, csr_bus.csr_rs1_idx}
                                      : csr_bus.csr_rs1_val;
        case (csr_bus.csr_op[1:0])
            2'b10:   writeData = readData | writeSrc;
            2'b11:   writeData = readData & ~writeSrc;
            default: writeData = writeSrc;
        endcase
        csrWrite = wantWrite && !illegal && !exception_i && !mret_i;
    end

    // Next-state for the architectural registers. Counters always advance;
    // a CSR write replaces only the written half's incremented value.
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mpp_d      = mpp_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;

        mcycleInc   = mcycle_q + 64'd1;
        minstretInc = minstret_q + {63'd0, instret_i};
        mcycle_d    = mcycleInc;
        minstret_d  = minstretInc;

        if (exception_i) begin
            mpie_d   = mie_q;
            mie_d    = 1'b0;
            mpp_d    = current_privilege_i;
            mepc_d   = exception_pc_i & ALIGN_MASK;
            mcause_d = exception_cause_i;
            mtval_d  = exception_tval_i;
        end else if (seqState_q == SEQ_MRET) begin
            // Second MRET phase: decode has already sampled the old MPP.
            mie_d  = mpie_q;
            mpie_d = 1'b1;
            mpp_d  = 2'b00;
        end

        if (csrWrite) begin
            case (csr_bus.csr_addr)
                ADDR_MSTATUS: begin
                    if (seqState_q != SEQ_MRET) begin
                        mie_d  = writeData[3];
                        mpie_d = writeData[7];
                        // Only M and U exist, so S/H encodings collapse to U.
                        mpp_d  = (writeData[12:11] == 2'b11) ? 2'b11 : 2'b00;
                    end
                end
                ADDR_MTVEC:     mtvec_d    = writeData & ALIGN_MASK;
                ADDR_MSCRATCH:  mscratch_d = writeData;
                ADDR_MEPC:      mepc_d     = writeData & ALIGN_MASK;
                ADDR_MCAUSE:    mcause_d   = writeData;
                ADDR_MTVAL:     mtval_d    = writeData;
                ADDR_MCYCLE:    mcycle_d[31:0]    = writeData;
                ADDR_MCYCLEH:   mcycle_d[63:32]   = writeData;
                ADDR_MINSTRET:  minstret_d[31:0]  = writeData;
                ADDR_MINSTRETH: minstret_d[63:32] = writeData;
                default: ;
            endcase
        end
    end

    // Architectural register update.
    always_ff @(posedge clk) begin
        if (rst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mpp_q      <= 2'b11;
            mtvec_q    <= MTVEC_RESET & ALIGN_MASK;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mpp_q      <= mpp_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    // Trap/MRET sequencer. An exception wins over MRET and also cancels a
    // pending MRET completion, so the two pulses can never overlap.
    always_ff @(posedge clk) begin
        if (rst) begin
            seqState_q      <= SEQ_IDLE;
            trap_redirect_q <= 1'b0;
            mret_out_q      <= 1'b0;
            redirect_pc_q   <= '0;
        end else if (exception_i) begin
            seqState_q      <= SEQ_TRAP;
            trap_redirect_q <= 1'b1;
            mret_out_q      <= 1'b0;
            redirect_pc_q   <= mtvec_q & ALIGN_MASK;
        end else if (mret_i) begin
            seqState_q      <= SEQ_MRET;
            trap_redirect_q <= 1'b0;
            mret_out_q      <= 1'b1;
            redirect_pc_q   <= mepc_q;
        end else begin
            seqState_q      <= SEQ_IDLE;
            trap_redirect_q <= 1'b0;
            mret_out_q      <= 1'b0;
        end
    end

    assign csr_bus.csr_rdata   = readData;
    assign csr_bus.illegal_csr = illegal;
    assign mstatus_o           = mstatusView;
    assign trap_redirect_o     = trap_redirect_q;
    assign mret_out_o          = mret_out_q;
    assign redirect_pc_o       = redirect_pc_q;

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file
//
// Self-checking bench for csr_file. A behavioural model keeps every
// architectural CSR in an associative array keyed by address, applies the
// legalisation rules on write and the trap/MRET rules on events. Directed
// steps cover reset, RMW chaining, trap entry, both MRET phases, counter
// wrap and illegal access; a randomized phase follows.

module tb_csr_file;

   localparam logic [31:0] MTVEC_P = 32'h0000_0203;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        exceptionReq = 1'b0;
   logic [31:0] exceptionCause = '0;
   logic [31:0] exceptionPc = '0;
   logic [31:0] exceptionTval = '0;
   logic        mretReq = 1'b0;
   logic        instret = 1'b0;
   logic [1:0]  privilege = 2'b11;
   logic [31:0] mstatusOut;
   logic        trapRedirect;
   logic        mretOut;
   logic [31:0] redirectPc;

   int vectorCount = 0;
   int missCount = 0;

   logic [31:0] csrModel [logic [11:0]];
   logic [63:0] minstretModel;

   logic [11:0] rwAddrs [6] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343};
   logic [2:0]  opList  [6] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

   csr_file_if bus ();

   csr_file #(
      .DATA_WIDTH (32),
      .MTVEC_RESET(MTVEC_P)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .csr_bus            (bus),
      .exception_i        (exceptionReq),
      .exception_cause_i  (exceptionCause),
      .exception_pc_i     (exceptionPc),
      .exception_tval_i   (exceptionTval),
      .mret_i             (mretReq),
      .instret_i          (instret),
      .current_privilege_i(privilege),
      .mstatus_o          (mstatusOut),
      .trap_redirect_o    (trapRedirect),
      .mret_out_o         (mretOut),
      .redirect_pc_o      (redirectPc)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Watchdog so a stuck run still reports and terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectorCount++;
      assert (observed === expected) else begin
         missCount++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] legalize(input logic [11:0] a, input logic [31:0] v);
      logic [31:0] r;
      r = v;
      case (a)
         12'h300: begin
            r = v & 32'h0000_1888;
            if (r[12:11] == 2'b01 || r[12:11] == 2'b10) r[12:11] = 2'b00;
         end
         12'h305, 12'h341: r = v & ~32'h0000_0003;
         default: r = v;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] modelRead(input logic [11:0] a);
      if (a == 12'h301) return 32'h4000_1100;
      if (csrModel.exists(a)) return csrModel[a];
      return 32'h0;
   endfunction

   task automatic modelReset();
      csrModel.delete();
      csrModel[12'h300] = 32'h0000_1800;
      csrModel[12'h305] = MTVEC_P & ~32'h0000_0003;
      minstretModel = 64'd0;
   endtask

   task automatic modelTrap(input logic [31:0] cause, input logic [31:0] pc, input logic [31:0] tval, input logic [1:0] priv);
      logic [31:0] st, ns;
      st = modelRead(12'h300);
      ns = 32'h0;
      ns[12:11] = priv;
      ns[7] = st[3];
      csrModel[12'h300] = ns;
      csrModel[12'h341] = pc & ~32'h0000_0003;
      csrModel[12'h342] = cause;
      csrModel[12'h343] = tval;
   endtask

   task automatic modelMretComplete();
      logic [31:0] st, ns;
      st = modelRead(12'h300);
      ns = 32'h0;
      ns[3] = st[7];
      ns[7] = 1'b1;
      csrModel[12'h300] = ns;
   endtask

   task automatic doReset();
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      modelReset();
   endtask

   // Zero-time read through a CSRRS x0 (never writes).
   task automatic readCsr(input logic [11:0] addr, input string tag);
      bus.csr_valid = 1'b1;
      bus.csr_op = 3'b010;
      bus.csr_addr = addr;
      bus.csr_rs1_idx = 5'd0;
      bus.csr_rs1_val = 32'hFFFF_FFFF;
      #1;
      checkOutput(tag, bus.csr_rdata, modelRead(addr));
      bus.csr_valid = 1'b0;
   endtask

   // One committed CSR instruction: checks old value, clocks, updates model.
   task automatic applyStimulus(input logic [2:0] op, input logic [11:0] addr, input logic [4:0] idx, input logic [31:0] val, input string tag);
      logic [31:0] src, oldv, newv;
      bus.csr_valid = 1'b1;
      bus.csr_op = op;
      bus.csr_addr = addr;
      bus.csr_rs1_idx = idx;
      bus.csr_rs1_val = val;
      #1;
      oldv = modelRead(addr);
      checkOutput({tag, "_old"}, bus.csr_rdata, oldv);
      src = op[2] ? {27'd0, idx} : val;
      case (op[1:0])
         2'b10:   newv = oldv | src;
         2'b11:   newv = oldv & ~src;
         default: newv = src;
      endcase
      @(posedge clk);
      #1;
      bus.csr_valid = 1'b0;
      if (!(op[1] && idx == 5'd0)) csrModel[addr] = legalize(addr, newv);
   endtask

   task automatic writeRaw(input logic [11:0] addr, input logic [31:0] val);
      bus.csr_valid = 1'b1;
      bus.csr_op = 3'b001;
      bus.csr_addr = addr;
      bus.csr_rs1_idx = 5'd1;
      bus.csr_rs1_val = val;
      @(posedge clk);
      #1;
      bus.csr_valid = 1'b0;
   endtask

   task automatic tryIllegal(input logic [2:0] op, input logic [11:0] addr, input logic [4:0] idx, input logic [31:0] expIllegal, input string tag);
      bus.csr_valid = 1'b1;
      bus.csr_op = op;
      bus.csr_addr = addr;
      bus.csr_rs1_idx = idx;
      bus.csr_rs1_val = 32'h5A5A_5A5A;
      #1;
      checkOutput(tag, {31'd0, bus.illegal_csr}, expIllegal);
      @(posedge clk);
      #1;
      bus.csr_valid = 1'b0;
   endtask

   task automatic raiseTrap(input logic [31:0] cause, input logic [31:0] pc, input logic [31:0] tval, input logic [1:0] priv, input string tag);
      logic [31:0] target;
      target = modelRead(12'h305);
      exceptionReq = 1'b1;
      exceptionCause = cause;
      exceptionPc = pc;
      exceptionTval = tval;
      privilege = priv;
      @(posedge clk);
      #1;
      exceptionReq = 1'b0;
      bus.csr_valid = 1'b0;
      modelTrap(cause, pc, tval, priv);
      checkOutput({tag, "_redirect"}, {31'd0, trapRedirect}, 32'd1);
      checkOutput({tag, "_mretout"}, {31'd0, mretOut}, 32'd0);
      checkOutput({tag, "_pc"}, redirectPc, target);
      checkOutput({tag, "_mstatus"}, mstatusOut, modelRead(12'h300));
   endtask

   task automatic checkAll(input string tag);
      foreach (rwAddrs[i]) readCsr(rwAddrs[i], tag);
   endtask

   initial begin
      logic [63:0] dummy;
      bus.csr_valid = 1'b0;
      bus.csr_op = 3'b000;
      bus.csr_addr = '0;
      bus.csr_rs1_idx = '0;
      bus.csr_rs1_val = '0;
      dummy = '0;

      // Reset state.
      doReset();
      checkOutput("rst_trap", {31'd0, trapRedirect}, 32'd0);
      checkOutput("rst_mret", {31'd0, mretOut}, 32'd0);
      checkOutput("rst_rpc", redirectPc, 32'd0);
      checkOutput("rst_mstatus", mstatusOut, 32'h0000_1800);
      readCsr(12'h300, "rst_rd300");
      readCsr(12'h301, "rst_rd301");
      readCsr(12'h305, "rst_mtvec");
      readCsr(12'hF14, "rst_hartid");

      // mscratch RMW chain.
      applyStimulus(3'b001, 12'h340, 5'd5, 32'hDEAD_BEEF, "rw_scratch");
      applyStimulus(3'b010, 12'h340, 5'd5, 32'h0000_0010, "rs_scratch");
      applyStimulus(3'b111, 12'h340, 5'h0F, 32'hFFFF_FFFF, "rci_scratch");
      readCsr(12'h340, "scratch_final");
      checkOutput("scratch_const", bus.csr_rdata, 32'hDEAD_BEF0);

      // Trap entry with a simultaneous (dropped) CSR write.
      applyStimulus(3'b001, 12'h305, 5'd1, 32'h0000_0103, "set_mtvec");
      applyStimulus(3'b110, 12'h300, 5'd8, 32'h0, "set_mie");
      bus.csr_valid = 1'b1;
      bus.csr_op = 3'b001;
      bus.csr_addr = 12'h340;
      bus.csr_rs1_idx = 5'd1;
      bus.csr_rs1_val = 32'h1111_1111;
      raiseTrap(32'd11, 32'h0000_0046, 32'h0000_ABCD, 2'b11, "trap1");
      checkOutput("trap1_pc_const", redirectPc, 32'h0000_0100);
      checkOutput("trap1_ms_const", mstatusOut, 32'h0000_1880);
      checkAll("trap1_regs");
      @(posedge clk);
      #1;
      checkOutput("trap1_pulse_end", {31'd0, trapRedirect}, 32'd0);

      // MRET two-phase.
      applyStimulus(3'b001, 12'h300, 5'd1, 32'h0000_0080, "mret_setup");
      mretReq = 1'b1;
      @(posedge clk);
      #1;
      mretReq = 1'b0;
      checkOutput("mret1_out", {31'd0, mretOut}, 32'd1);
      checkOutput("mret1_trap", {31'd0, trapRedirect}, 32'd0);
      checkOutput("mret1_pc", redirectPc, modelRead(12'h341));
      checkOutput("mret1_mstatus", mstatusOut, modelRead(12'h300));
      @(posedge clk);
      #1;
      modelMretComplete();
      checkOutput("mret2_out", {31'd0, mretOut}, 32'd0);
      checkOutput("mret2_mstatus", mstatusOut, modelRead(12'h300));
      checkOutput("mret2_ms_const", mstatusOut, 32'h0000_0088);

      // Exception on the edge of the pending MRET update.
      applyStimulus(3'b001, 12'h300, 5'd1, 32'h0000_0080, "mx_setup");
      mretReq = 1'b1;
      @(posedge clk);
      #1;
      mretReq = 1'b0;
      checkOutput("mx_out", {31'd0, mretOut}, 32'd1);
      raiseTrap(32'd2, 32'h0000_0203, 32'h0, 2'b00, "mx_trap");
      checkAll("mx_regs");

      // Reset while MRET is pending.
      mretReq = 1'b1;
      @(posedge clk);
      #1;
      mretReq = 1'b0;
      checkOutput("rm_out_pre", {31'd0, mretOut}, 32'd1);
      doReset();
      checkOutput("rm_out", {31'd0, mretOut}, 32'd0);
      checkOutput("rm_trap", {31'd0, trapRedirect}, 32'd0);
      checkOutput("rm_rpc", redirectPc, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("rm_mstatus", mstatusOut, 32'h0000_1800);

      // mcycle wrap, both halves read in the same cycle.
      writeRaw(12'hB80, 32'hFFFF_FFFF);
      writeRaw(12'hB00, 32'hFFFF_FFFF);
      @(posedge clk);
      #1;
      bus.csr_valid = 1'b1;
      bus.csr_op = 3'b010;
      bus.csr_rs1_idx = 5'd0;
      bus.csr_addr = 12'hB00;
      #1;
      checkOutput("mcycle_lo_wrap", bus.csr_rdata, 32'h0);
      bus.csr_addr = 12'hB80;
      #1;
      checkOutput("mcycle_hi_wrap", bus.csr_rdata, 32'h0);
      bus.csr_valid = 1'b0;

      // minstret follows random retire pulses.
      @(posedge clk);
      #1;
      for (int i = 0; i < 24; i++) begin
         instret = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         if (instret) minstretModel = minstretModel + 64'd1;
      end
      instret = 1'b0;
      bus.csr_valid = 1'b1;
      bus.csr_op = 3'b010;
      bus.csr_rs1_idx = 5'd0;
      bus.csr_addr = 12'hB02;
      #1;
      checkOutput("minstret_lo", bus.csr_rdata, minstretModel[31:0]);
      bus.csr_addr = 12'hB82;
      #1;
      checkOutput("minstret_hi", bus.csr_rdata, minstretModel[63:32]);
      bus.csr_valid = 1'b0;

      // Illegal accesses leave state alone.
      applyStimulus(3'b001, 12'h340, 5'd2, 32'h1234_5678, "ill_setup");
      tryIllegal(3'b001, 12'hF14, 5'd3, 32'd1, "ill_hartid");
      tryIllegal(3'b001, 12'h7C0, 5'd3, 32'd1, "ill_7c0");
      tryIllegal(3'b010, 12'h301, 5'd4, 32'd1, "ill_misa_rs");
      tryIllegal(3'b010, 12'h301, 5'd0, 32'd0, "ill_misa_rs0");
      readCsr(12'h301, "misa_rs0_rd");
      readCsr(12'hF14, "hartid_after");
      checkAll("ill_regs");

      // MPP legalisation.
      applyStimulus(3'b001, 12'h300, 5'd1, 32'h0000_0800, "mpp01");
      checkOutput("mpp01_ms", mstatusOut, 32'h0000_0000);
      applyStimulus(3'b001, 12'h300, 5'd1, 32'hFFFF_F7FF, "mpp10");
      checkOutput("mpp10_ms", mstatusOut, 32'h0000_0088);

      // Randomized back-to-back RMW traffic.
      for (int i = 0; i < 40; i++) begin
         logic [11:0] a;
         logic [2:0]  op;
         logic [4:0]  idx;
         a = rwAddrs[$urandom_range(0, 5)];
         op = opList[$urandom_range(0, 5)];
         idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         applyStimulus(op, a, idx, $urandom, "rand");
         checkOutput("rand_mstatus", mstatusOut, modelRead(12'h300));
      end
      checkAll("rand_final");

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
